// File: rtl/mem_write_pkg.sv
// Shared types for the AXI write master: request record, AXI write channel bundles and FSM states.
package mem_write_pkg;

    localparam int unsigned LINE_BYTE_OFFSET = 6;
    localparam int unsigned LINE_WORDS       = 2 ** (LINE_BYTE_OFFSET - 2);
    localparam int unsigned BEAT_W           = LINE_BYTE_OFFSET - 2;
    localparam int unsigned TAG_W            = 32 - LINE_BYTE_OFFSET;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef struct packed {
        logic [31:0]                  startaddr;
        logic [3:0]                   len;
        logic [2:0]                   size;
        logic [3:0]                   strb;
        logic [LINE_WORDS-1:0][31:0]  data;
    } mem_write_req;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_w_req;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_resp;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} mem_write_state_t;

endpackage

// File: rtl/mem_write_req_fifo.sv
// Request queue for mem_write: FIFO storage plus per-entry valid bits and line tags so queued
// and in-flight writes can be probed by the read path.
module mem_write_req_fifo
    import mem_write_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  mem_write_req i_data,
    input  logic         i_pop,
    input  logic [31:0]  i_probe_addr,
    output mem_write_req o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_probe_hit
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    mem_write_req               mem_q [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic                       do_push, do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    // Full is registered, so a push while full is dropped even if the head retires this cycle.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            tag_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
                tag_q[wr_ptr_q]   <= i_data.startaddr[31:LINE_BYTE_OFFSET];
            end
            if (do_pop) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        o_probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == i_probe_addr[31:LINE_BYTE_OFFSET])) begin
                o_probe_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write.sv
// AXI write master: queues line writebacks and single stores, issues one AW/W/B transaction
// at a time in order, and flags the active line to the read path.
module mem_write
    import mem_write_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  AXI_ID = 4'h0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  mem_write_req i_req,
    input  logic         i_we,
    input  logic [31:0]  i_probe_addr,
    output logic         o_probe_hit,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_write_process,
    output logic [31:0]  o_write_address,
    output logic         o_done,
    output logic         o_bus_error,
    output axi_w_req     axi_bus_req,
    input  axi_w_resp    axi_bus_resp
);

    mem_write_state_t  state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    mem_write_req      head;
    logic              fifo_empty;
    logic              fifo_pop;

    mem_write_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (i_we),
        .i_data       (i_req),
        .i_pop        (fifo_pop),
        .i_probe_addr (i_probe_addr),
        .o_head       (head),
        .o_full       (o_full),
        .o_empty      (fifo_empty),
        .o_probe_hit  (o_probe_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        fifo_pop         = 1'b0;
        o_done           = 1'b0;
        o_bus_error      = 1'b0;
        axi_bus_req      = '0;
        axi_bus_req.awid = AXI_ID;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ADDR;
            end
            ADDR: begin
                axi_bus_req.awvalid = 1'b1;
                axi_bus_req.awaddr  = head.startaddr;
                axi_bus_req.awlen   = {4'b0, head.len};
                axi_bus_req.awsize  = head.size;
                axi_bus_req.awburst = (head.len == '0) ? BURST_FIXED : BURST_INCR;
                if (axi_bus_resp.awready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                axi_bus_req.wvalid = 1'b1;
                axi_bus_req.wdata  = head.data[beat_q];
                axi_bus_req.wstrb  = (head.len == '0) ? head.strb : 4'hF;
                axi_bus_req.wlast  = (beat_q == head.len);
                if (axi_bus_resp.wready) begin
                    if (axi_bus_req.wlast) state_d = RESP;
                    else                   beat_d  = beat_q + 1'b1;
                end
            end
            RESP: begin
                axi_bus_req.bready = 1'b1;
                // Errored writes are still retired; the requester sees o_bus_error.
                if (axi_bus_resp.bvalid) begin
                    fifo_pop    = 1'b1;
                    o_done      = 1'b1;
                    o_bus_error = (axi_bus_resp.bresp != 2'b00);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_empty         = fifo_empty && (state_q == IDLE);
    assign o_write_process = (state_q != IDLE);
    assign o_write_address = o_write_process ? head.startaddr : 32'h0;

endmodule

// File: tb/tb_mem_write.sv
// Randomised scoreboard bench for mem_write: a queue model of accepted writes is compared
// against every AXI handshake, probe result and status flag each cycle.
module tb_mem_write;
    import mem_write_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    mem_write_req req = '0;
    logic         we = 1'b0;
    logic [31:0]  probe = 32'h0;
    logic         probe_hit, full, empty, wproc, done, berr;
    logic [31:0]  waddr;
    axi_w_req     axi_req;
    axi_w_resp    axi_resp = '0;

    always #5 clk = ~clk;

    mem_write #(
        .DEPTH  (DEPTH),
        .AXI_ID (4'h0)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req           (req),
        .i_we            (we),
        .i_probe_addr    (probe),
        .o_probe_hit     (probe_hit),
        .o_full          (full),
        .o_empty         (empty),
        .o_write_process (wproc),
        .o_write_address (waddr),
        .o_done          (done),
        .o_bus_error     (berr),
        .axi_bus_req     (axi_req),
        .axi_bus_resp    (axi_resp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    mem_write_req model_q[$];
    mem_write_req incoming[$];
    bit in_reset = 1'b1;
    bit aw_done  = 1'b0;
    int beat = 0, n_done = 0, n_err = 0;
    int aw_pct = 100, w_pct = 100, b_pct = 100, err_pct = 0;
    bit w_toggle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit line_hit(input logic [31:0] a);
        foreach (model_q[i]) begin
            if (model_q[i].startaddr[31:6] == a[31:6]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic mem_write_req make_req(input logic [31:0] a, input logic [3:0] len,
                                              input logic [3:0] strb, input bit idx_data);
        mem_write_req r;
        r.startaddr = a;
        r.len       = len;
        r.size      = 3'd2;
        r.strb      = strb;
        for (int i = 0; i < LINE_WORDS; i++) r.data[i] = idx_data ? 32'(i) : $urandom;
        return r;
    endfunction

    // AXI slave responder
    always @(negedge clk) begin
        axi_resp.awready = ($urandom_range(99) < aw_pct);
        if (w_toggle) axi_resp.wready = ~axi_resp.wready;
        else          axi_resp.wready = ($urandom_range(99) < w_pct);
        axi_resp.bvalid = ($urandom_range(99) < b_pct);
        axi_resp.bresp  = ($urandom_range(99) < err_pct) ? 2'b10 : 2'b00;
        axi_resp.bid    = 4'h0;
    end

    // Monitor: evaluates the handshakes that will complete at the coming rising edge.
    initial begin
        forever begin
            mem_write_req h;
            @(negedge clk);
            #2;
            if (!in_reset) begin
                check("probe_hit", probe_hit, line_hit(probe));
                check("full", full, model_q.size() == DEPTH);
                check("empty", empty, model_q.size() == 0);
                if (model_q.size() == 0) check("idle_addr", {wproc, waddr}, 33'h0);
                if (aw_done) check("active_addr", {wproc, waddr}, {1'b1, model_q[0].startaddr});
                check("aw_while_busy", axi_req.awvalid && (aw_done || model_q.size() == 0), 0);
                check("w_before_aw", axi_req.wvalid && !aw_done, 0);
                if (axi_req.awvalid && axi_resp.awready && !aw_done && model_q.size() != 0) begin
                    h = model_q[0];
                    check("aw", {axi_req.awaddr, axi_req.awlen, axi_req.awsize, axi_req.awburst,
                                 axi_req.awid, axi_req.awlock, axi_req.awcache, axi_req.awprot},
                          {h.startaddr, 8'(h.len), h.size, (h.len == 0) ? 2'b00 : 2'b01,
                           4'h0, 1'b0, 4'h0, 3'h0});
                    check("aw_write_address", {wproc, waddr}, {1'b1, h.startaddr});
                    aw_done = 1'b1;
                    beat    = 0;
                end else if (axi_req.wvalid && aw_done) begin
                    h = model_q[0];
                    check("w_extra", beat > int'(h.len), 0);
                    if (axi_resp.wready && beat <= int'(h.len)) begin
                        check("w", {axi_req.wdata, axi_req.wstrb, axi_req.wlast},
                              {h.data[beat], (h.len == 0) ? h.strb : 4'hF, beat == int'(h.len)});
                        beat++;
                    end
                end
                if (axi_req.bready && axi_resp.bvalid && model_q.size() != 0) begin
                    h = model_q[0];
                    check("b_after_all_w", beat, int'(h.len) + 1);
                    check("done_pulse", {done, berr}, {1'b1, axi_resp.bresp != 2'b00});
                    if (axi_resp.bresp != 2'b00) n_err++;
                    void'(model_q.pop_front());
                    aw_done = 1'b0;
                    n_done++;
                end else begin
                    check("no_done", {done, berr}, 2'b00);
                end
                while (incoming.size() != 0) model_q.push_back(incoming.pop_front());
            end
        end
    end

    task automatic push(input mem_write_req r);
        @(negedge clk);
        check("full_at_push", full, model_q.size() == DEPTH);
        req = r;
        we  = 1'b1;
        if (model_q.size() < DEPTH) incoming.push_back(r);
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while ((model_q.size() != 0 || incoming.size() != 0) && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check("drain_timeout", model_q.size() + incoming.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0, e0, c;
        mem_write_req r;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {axi_req.awvalid, axi_req.wvalid, axi_req.bready, full, empty,
                                wproc, waddr, done, berr}, {5'b00001, 1'b0, 32'h0, 2'b00});
        rst_n = 1'b1;
        in_reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single uncached store
        d0 = n_done;
        r = make_req(32'h1000_0004, 4'd0, 4'b0011, 1'b0);
        r.data[0] = 32'hDEAD_BEEF;
        push(r);
        drain(100);
        check("single_done_count", n_done - d0, 1);

        // Line writeback, wready toggling
        w_toggle = 1'b1;
        push(make_req(32'h0000_0040, 4'd15, 4'h0, 1'b1));
        drain(200);
        w_toggle = 1'b0;

        // Backpressure: fifth push dropped while AW is stalled
        aw_pct = 0;
        d0 = n_done;
        for (int i = 0; i < 5; i++) push(make_req(32'h4000_0000 + 32'(i * 64), 4'(i), 4'hF, 1'b0));
        repeat (20) @(negedge clk);
        aw_pct = 100;
        drain(400);
        check("backpressure_done_count", n_done - d0, 4);

        // Probe against queued lines
        aw_pct = 0;
        probe  = 32'h2000_003C;
        push(make_req(32'h2000_0000, 4'd0, 4'hF, 1'b0));
        push(make_req(32'h2000_0100, 4'd3, 4'hF, 1'b0));
        repeat (3) @(negedge clk);
        probe = 32'h2000_0040;
        repeat (3) @(negedge clk);
        probe = 32'h2000_013C;
        repeat (2) @(negedge clk);
        probe  = 32'h2000_003C;
        aw_pct = 100;
        drain(200);

        // Bus error on first of two writes
        d0 = n_done;
        e0 = n_err;
        err_pct = 100;
        push(make_req(32'h5000_0000, 4'd0, 4'h1, 1'b0));
        push(make_req(32'h5000_0040, 4'd1, 4'hF, 1'b0));
        c = 0;
        while (n_done == d0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        err_pct = 0;
        drain(200);
        check("bus_error_count", n_err - e0, 1);
        check("error_done_count", n_done - d0, 2);

        // Randomised traffic
        aw_pct = 70; w_pct = 60; b_pct = 50; err_pct = 10;
        for (int i = 0; i < 60; i++) begin
            r = make_req(32'h3000_0000 | (32'($urandom_range(7)) << 6) | (32'($urandom_range(15)) << 2),
                         ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15)),
                         4'($urandom_range(15)), 1'b0);
            probe = 32'h3000_0000 | (32'($urandom_range(9)) << 6);
            push(r);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        drain(4000);
        err_pct = 0; aw_pct = 100; b_pct = 100;

        // Reset in the middle of a line burst
        w_pct = 50;
        push(make_req(32'h0000_0080, 4'd15, 4'h0, 1'b1));
        c = 0;
        while (!(aw_done && beat == 7) && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("reached_beat7", beat, 7);
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midburst_reset", {axi_req.awvalid, axi_req.wvalid, axi_req.bready, empty, done, wproc},
              6'b000100);
        model_q.delete();
        incoming.delete();
        aw_done = 1'b0;
        beat    = 0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        d0 = n_done;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", n_done - d0, 0);
        w_pct = 100;
        push(make_req(32'h6000_0010, 4'd0, 4'b1000, 1'b0));
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
